// File: rtl/counter_7seg_mux_if.sv
// Word-addressed bus between the Wishbone slave decode and the counter block.
// Each request gets a one-cycle ready pulse.
interface counter_7seg_mux_if;
    logic        valid;
    logic        we;
    logic [1:0]  addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;

    modport master (
        output valid, we, addr, wstrb, wdata,
        input  ready, rdata
    );

    modport slave (
        input  valid, we, addr, wstrb, wdata,
        output ready, rdata
    );
endinterface

// File: rtl/counter_7seg_mux.sv
// Up/down counter with bus and LA load. It drives a time-multiplexed N-digit
// 7-segment display and can blank leading zeros.
module counter_7seg_mux #(
    parameter int unsigned BITS     = 16,
    parameter int unsigned DIGITS   = BITS / 4,
    parameter int unsigned SCAN_DIV = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    counter_7seg_mux_if.slave     bus,
    input  logic [BITS-1:0]       la_write,
    input  logic [BITS-1:0]       la_input,
    output logic [BITS-1:0]       count,
    output logic [6:0]            segments,
    output logic [DIGITS-1:0]     digit_sel,
    output logic [6+DIGITS:0]     out_oeb
);

    localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [BITS-1:0]     count_q, count_d;
    logic [2:0]          ctrl_q, ctrl_d;
    logic                ready_q, ready_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [SCAN_DIV-1:0] presc_q, presc_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [6:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   sel_q, sel_d;

    logic            ack, count_wr, ctrl_wr;
    logic [31:0]     lane_mask;
    logic [BITS-1:0] upper;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b0111111;
            4'h1: seg = 7'b0000110;
            4'h2: seg = 7'b1011011;
            4'h3: seg = 7'b1001111;
            4'h4: seg = 7'b1100110;
            4'h5: seg = 7'b1101101;
            4'h6: seg = 7'b1111101;
            4'h7: seg = 7'b0000111;
            4'h8: seg = 7'b1111111;
            4'h9: seg = 7'b1100111;
            4'hA: seg = 7'b1110111;
            4'hB: seg = 7'b1111100;
            4'hC: seg = 7'b0111001;
            4'hD: seg = 7'b1011110;
            4'hE: seg = 7'b1111001;
            default: seg = 7'b1110001;
        endcase
        return seg;
    endfunction

    always_comb begin
        ack       = bus.valid && !ready_q;
        count_wr  = ack && bus.we && (bus.addr == 2'd0);
        ctrl_wr   = ack && bus.we && (bus.addr == 2'd1) && bus.wstrb[0];
        lane_mask = {{8{bus.wstrb[3]}}, {8{bus.wstrb[2]}}, {8{bus.wstrb[1]}}, {8{bus.wstrb[0]}}};
        ready_d   = ack;

        // Bus write beats LA load, and LA load beats stepping. Stepping uses the old CTRL.
        count_d = count_q;
        if (count_wr) begin
            count_d = (count_q & ~lane_mask[BITS-1:0]) | (bus.wdata[BITS-1:0] & lane_mask[BITS-1:0]);
        end else if (|la_write) begin
            count_d = (count_q & ~la_write) | (la_input & la_write);
        end else if (ctrl_q[0]) begin
            count_d = ctrl_q[1] ? count_q - 1'b1 : count_q + 1'b1;
        end

        ctrl_d = ctrl_wr ? bus.wdata[2:0] : ctrl_q;

        rdata_d = rdata_q;
        if (ack) begin
            case (bus.addr)
                2'd0:    rdata_d = 32'(count_q);
                2'd1:    rdata_d = {29'b0, ctrl_q};
                default: rdata_d = '0;
            endcase
        end

        presc_d = presc_q + 1'b1;
        idx_d   = idx_q;
        if (&presc_q) begin
            idx_d = (idx_q == IdxW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end

        // The current nibble sits in upper[3:0]. If all of upper is zero, every
        // nibble from idx_q up to the top digit is zero.
        upper = count_q >> {idx_q, 2'b00};
        seg_d = (ctrl_q[2] && (idx_q != '0) && (upper == '0)) ? 7'b0 : hex_to_seg(upper[3:0]);
        sel_d = DIGITS'(1) << idx_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            ctrl_q  <= 3'b001;
            ready_q <= 1'b0;
            rdata_q <= '0;
            presc_q <= '0;
            idx_q   <= '0;
            seg_q   <= 7'b0111111;
            sel_q   <= DIGITS'(1);
        end else begin
            count_q <= count_d;
            ctrl_q  <= ctrl_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            sel_q   <= sel_d;
        end
    end

    assign count     = count_q;
    assign segments  = seg_q;
    assign digit_sel = sel_q;
    assign bus.ready = ready_q;
    assign bus.rdata = rdata_q;
    assign out_oeb   = {(7 + DIGITS){~reset_n}};

endmodule

// File: tb/tb_counter_7seg_mux.sv
// Directed bench for counter_7seg_mux with BITS=16 and SCAN_DIV=2.
// It uses hand-computed expectations.
module tb_counter_7seg_mux;

    localparam int unsigned BITS     = 16;
    localparam int unsigned DIGITS   = 4;
    localparam int unsigned SCAN_DIV = 2;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [BITS-1:0]   la_write;
    logic [BITS-1:0]   la_input;
    logic [BITS-1:0]   count;
    logic [6:0]        segments;
    logic [DIGITS-1:0] digit_sel;
    logic [6+DIGITS:0] out_oeb;

    counter_7seg_mux_if bus ();

    counter_7seg_mux #(
        .BITS     (BITS),
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .la_write  (la_write),
        .la_input  (la_input),
        .count     (count),
        .segments  (segments),
        .digit_sel (digit_sel),
        .out_oeb   (out_oeb)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;  // rising edges since reset release

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Drives one request and samples the ack edge. valid is low again when the task returns.
    task automatic bus_xfer(input logic w, input logic [1:0] a, input logic [3:0] s,
                            input logic [31:0] d);
        bus.valid = 1'b1;
        bus.we    = w;
        bus.addr  = a;
        bus.wstrb = s;
        bus.wdata = d;
        tick();
        check("bus_ready", 32'(bus.ready), 32'd1);
        bus.valid = 1'b0;
        bus.we    = 1'b0;
    endtask

    // Expected scan state after edge cyc, for counts that were stable on the previous cycle.
    task automatic check_scan(input string tag, input logic [15:0] cnt, input logic blank);
        int         idx;
        logic [3:0] nib;
        logic [6:0] exp_seg;
        idx = ((cyc - 1) / 4) % 4;
        nib = 4'((cnt >> (4 * idx)) & 16'hF);
        exp_seg = seg_tab[nib];
        if (blank && idx != 0 && (cnt >> (4 * idx)) == 0) exp_seg = 7'b0;
        check({tag, "_sel"}, 32'(digit_sel), 32'(1 << idx));
        check({tag, "_seg"}, 32'(segments), 32'(exp_seg));
    endtask

    initial begin
        reset_n   = 1'b0;
        bus.valid = 1'b0;
        bus.we    = 1'b0;
        bus.addr  = 2'd0;
        bus.wstrb = 4'd0;
        bus.wdata = 32'd0;
        la_write  = '0;
        la_input  = '0;

        tick();
        tick();
        check("rst_oeb", 32'(out_oeb), 32'h7FF);
        check("rst_count", 32'(count), 32'h0);
        check("rst_ready", 32'(bus.ready), 32'h0);
        check("rst_rdata", bus.rdata, 32'h0);
        check("rst_seg", 32'(segments), 32'h3F);
        check("rst_sel", 32'(digit_sel), 32'h1);

        reset_n = 1'b1;
        cyc = 0;
        #1;
        check("run_oeb", 32'(out_oeb), 32'h0);
        for (int i = 1; i <= 20; i++) begin
            tick();
            check("run_count", 32'(count), 32'(i));
            check_scan("run", 16'(i - 1), 1'b0);
        end

        // Switch to count down. The CTRL write cycle still steps up with the old CTRL.
        bus_xfer(1'b1, 2'd1, 4'hF, 32'h3);
        check("ctrl_step_old", 32'(count), 32'd21);
        tick();
        check("ready_drop", 32'(bus.ready), 32'd0);
        check("down_step", 32'(count), 32'd20);
        bus_xfer(1'b1, 2'd0, 4'b0011, 32'h0001);
        check("cnt_wr", 32'(count), 32'h0001);
        tick();
        check("down_to0", 32'(count), 32'h0000);
        tick();
        check("down_wrap", 32'(count), 32'hFFFF);

        // Disable counting. Then check that a bus write beats an LA load in the same cycle.
        bus_xfer(1'b1, 2'd1, 4'h1, 32'h0);
        tick();
        bus_xfer(1'b1, 2'd0, 4'hF, 32'hABCD1234);
        check("cnt_wr_full", 32'(count), 32'h1234);
        tick();
        check("hold_dis", 32'(count), 32'h1234);
        la_write = 16'hFFFF;
        la_input = 16'hBEEF;
        bus_xfer(1'b1, 2'd0, 4'b0001, 32'h000000A5);
        check("bus_beats_la", 32'(count), 32'h12A5);
        tick();
        check("la_full", 32'(count), 32'hBEEF);
        la_write = '0;

        // Partial LA load
        bus_xfer(1'b1, 2'd0, 4'hF, 32'h1234);
        la_write = 16'h00F0;
        la_input = 16'h0050;
        tick();
        check("la_mask", 32'(count), 32'h1254);
        la_write = '0;
        tick();
        tick();
        check("la_hold", 32'(count), 32'h1254);

        // Leading-zero blanking
        bus_xfer(1'b1, 2'd1, 4'h1, 32'h4);
        tick();
        bus_xfer(1'b1, 2'd0, 4'h3, 32'h0007);
        tick();
        for (int i = 0; i < 16; i++) begin
            tick();
            check_scan("blank7", 16'h0007, 1'b1);
        end
        bus_xfer(1'b1, 2'd0, 4'h3, 32'h0000);
        tick();
        for (int i = 0; i < 16; i++) begin
            tick();
            check_scan("blank0", 16'h0000, 1'b1);
        end

        // Register reads
        bus_xfer(1'b0, 2'd1, 4'h0, 32'h0);
        check("rd_ctrl", bus.rdata, 32'h4);
        tick();
        bus_xfer(1'b0, 2'd2, 4'h0, 32'h0);
        check("rd_unmapped", bus.rdata, 32'h0);
        tick();

        // Re-enable counting. The write cycle itself does not step.
        bus_xfer(1'b1, 2'd1, 4'h1, 32'h1);
        check("ctrl_en_nostep", 32'(count), 32'h0);
        tick();
        check("en_step", 32'(count), 32'h1);

        // Hold valid high for back-to-back reads
        bus.valid = 1'b1;
        bus.we    = 1'b0;
        bus.addr  = 2'd0;
        tick();
        check("rd1_ready", 32'(bus.ready), 32'd1);
        check("rd1_rdata", bus.rdata, 32'h1);
        tick();
        check("rd2_ready", 32'(bus.ready), 32'd0);
        tick();
        check("rd3_ready", 32'(bus.ready), 32'd1);
        check("rd3_rdata", bus.rdata, 32'h3);
        tick();
        check("rd4_ready", 32'(bus.ready), 32'd0);
        tick();
        check("rd5_ready", 32'(bus.ready), 32'd1);

        // Reset while ready is high: everything clears immediately.
        reset_n = 1'b0;
        #1;
        check("midrst_ready", 32'(bus.ready), 32'd0);
        check("midrst_rdata", bus.rdata, 32'h0);
        check("midrst_count", 32'(count), 32'h0);
        check("midrst_oeb", 32'(out_oeb), 32'h7FF);
        check("midrst_sel", 32'(digit_sel), 32'h1);
        check("midrst_seg", 32'(segments), 32'h3F);
        bus.valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/counter_7seg_mux.md
Name: counter_7seg_mux

Overview:
- Parametrised successor to the single-digit counter/7-seg user project.
- Up/down counter with enable, bus load, and bitwise LA load. Drives a time-multiplexed N-digit common 7-segment display with optional leading-zero blanking.
- Sits in the user project area between the Wishbone slave decode, the LA probes, and the GPIO pads.

Parameters:
- BITS, 16, counter width; must be a multiple of 4, range 8..32.
- DIGITS, BITS/4, number of hex digits scanned; one nibble per digit.
- SCAN_DIV, 10, width of the scan prescaler; digit dwell time = 2^SCAN_DIV clocks.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- valid  in  1  bus request (cyc & stb).
- we  in  1  bus write.
- addr  in  2  word select: 0=COUNT, 1=CTRL, 2/3 read 0, writes ignored.
- wstrb  in  4  byte strobes, active only when we=1.
- wdata  in  32  write data.
- ready  out  1  one-cycle acknowledge.
- rdata  out  32  read data, zero-extended.
- la_write  in  BITS  per-bit LA load mask.
- la_input  in  BITS  LA load data.
- count  out  BITS  current counter value.
- segments  out  7  segment pattern, bit6..0 = g..a, active-high.
- digit_sel  out  DIGITS  one-hot digit enable, active-high; bit0 = least significant nibble.
- out_oeb  out  7+DIGITS  pad output enables, all 1 while reset_n=0, else all 0 (combinational).

Behaviour:
- Reset (async, reset_n=0): count=0, CTRL=3'b001, ready=0, rdata=0, prescaler=0, digit index=0, digit_sel=1, segments=7'b0111111.
- CTRL[0] = enable, CTRL[1] = down, CTRL[2] = blank leading zeros. CTRL[31:3] read 0.
- Bus handshake: on valid && !ready, ready=1 for exactly one cycle.
  - rdata is latched with the selected register's value from before any write in that cycle.
  - valid held high gives ready 1,0,1,0…; each ready is a separate transaction.
- Bus writes:
  - COUNT: byte lanes via wstrb, limited to bytes below BITS.
  - CTRL: uses wstrb[0] only.
  - Writes take effect on the ack cycle.
- Count update priority each cycle, highest first:
  - (1) bus write to COUNT: written lanes take wdata, unwritten lanes hold; no count step that cycle.
  - (2) |la_write: count = (count & ~la_write) | (la_input & la_write); no step.
  - (3) enable: count ± 1, modulo 2^BITS. Up wraps all-ones→0; down wraps 0→all-ones.
  - (4) otherwise hold.
- A CTRL write does not block stepping in the same cycle. The step uses the old CTRL; the new CTRL applies the next cycle.
- Scan:
  - Prescaler increments every cycle.
  - When the prescaler equals all-ones, the digit index advances by one, wrapping DIGITS-1→0.
  - segments and digit_sel are registered from the new index and the current count. They change together, one cycle after the index changes, so there is no mixed digit/segment glitch.
- Decode: hex 0-F, standard patterns. 0=0111111, 1=0000110, 6=1111101, 7=0000111, 9=1100111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001.
- Blanking: when CTRL[2]=1 and index>0 and all nibbles from index up to DIGITS-1 are 0, segments=0. digit_sel still asserts. Digit 0 is never blanked.
- Reset mid-scan or mid-transaction: immediate return to reset values. A pending ack is dropped, and the master must retry.

Test Plan (BITS=16, SCAN_DIV=2):
- Reset, then release; observe 20 cycles → count increments 0,1,2…; digit_sel sequence 0001→0010→0100→1000→0001 with dwell 4 cycles; out_oeb 0 after release, all 1 during reset.
- Write CTRL=3'b011, then COUNT=0x0001 with wstrb=4'b0011 → ready pulses once per write; count 0x0001, 0x0000, then 0xFFFF (down wrap).
- Write COUNT=0x00A5 with wstrb=4'b0001 while count=0x1234 and la_write=0xFFFF → count=0x12A5 (bus beats LA); next cycle count=la_input.
- la_write=0x00F0, la_input=0x0050, enable=0, count=0x1234 → count=0x1254 and holds.
- CTRL=3'b100 (disabled, blanking), COUNT=0x0007 → digits 3..1 show segments=0, digit 0 shows 0000111. COUNT=0x0000 → digit 0 shows 0111111, the others are blank.
- Hold valid high for a 4-cycle read of COUNT → ready=1,0,1,0; each rdata is the pre-cycle count. Assert reset_n=0 while ready=1 → ready=0 immediately.
